// File: rtl/display_scan_capture.sv
// Captures the four digits of a multiplexed active-low 7-segment display.
// Each anode dwell is sampled once after settling; a frame is published after all four digits are sampled.
module dsc_slot (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       err,
  output logic       blank
);
  logic [3:0] dec_nib;
  logic       dec_err, dec_blank;

  // Segment patterns are active-low {a,b,c,d,e,f,g}.
  always_comb begin
    dec_nib   = 4'h0;
    dec_err   = 1'b0;
    dec_blank = 1'b0;
    case (seg)
      7'h01: dec_nib = 4'h0;
      7'h4F: dec_nib = 4'h1;
      7'h12: dec_nib = 4'h2;
      7'h06: dec_nib = 4'h3;
      7'h4C: dec_nib = 4'h4;
      7'h24: dec_nib = 4'h5;
      7'h20: dec_nib = 4'h6;
      7'h0F: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h04: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h60: dec_nib = 4'hB;
      7'h31: dec_nib = 4'hC;
      7'h42: dec_nib = 4'hD;
      7'h30: dec_nib = 4'hE;
      7'h38: dec_nib = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      nib   <= 4'h0;
      err   <= 1'b0;
      blank <= 1'b0;
    end else if (load) begin
      nib   <= dec_nib;
      err   <= dec_err;
      blank <= dec_blank;
    end
  end
endmodule

module display_scan_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Anode,
  input  logic [6:0]  LED_i,
  output logic [15:0] value,
  output logic        valid,
  output logic [3:0]  err,
  output logic [3:0]  blank,
  output logic        stale
);
  localparam int NUM_LANES = 4;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    SETTLE_W = 8'(SETTLE_CYCLES);
  localparam logic [CW-1:0] TO_W     = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t state, next_state;
  logic [3:0]  anode_q, anode_prev;
  logic [6:0]  led_q;
  logic [7:0]  dwell, dwell_nxt;
  logic        anode_ok, changed, sample, frame_done;
  logic [NUM_LANES-1:0] seen, load;
  logic [NUM_LANES-1:0][3:0] slot_nib;
  logic [NUM_LANES-1:0] slot_err, slot_blank;
  logic [CW-1:0] stale_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      anode_q    <= 4'hF;
      led_q      <= 7'h7F;
      anode_prev <= 4'hF;
    end else begin
      anode_q    <= Anode;
      led_q      <= LED_i;
      anode_prev <= anode_q;
    end
  end

  assign anode_ok = ($countones(~anode_q) == 1);
  assign changed  = (anode_q != anode_prev);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      dwell <= 8'd0;
    end else begin
      state <= next_state;
      dwell <= dwell_nxt;
    end
  end

  // A fresh or changed anode restarts the dwell at 1; sampling happens when the
  // post-edge count reaches SETTLE_CYCLES, so HOLD blocks a second sample.
  always_comb begin
    next_state = state;
    dwell_nxt  = dwell;
    sample     = 1'b0;
    if (!anode_ok) begin
      next_state = IDLE;
      dwell_nxt  = 8'd0;
    end else if (state == IDLE || changed) begin
      next_state = SETTLE;
      dwell_nxt  = 8'd1;
    end else if (state == SETTLE) begin
      dwell_nxt = dwell + 8'd1;
    end
    if (next_state == SETTLE && dwell_nxt == SETTLE_W) begin
      sample     = 1'b1;
      next_state = HOLD;
    end
  end

  assign load = {NUM_LANES{sample}} & ~anode_q;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_slot
      dsc_slot u_slot (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (load[g]),
        .seg   (led_q),
        .nib   (slot_nib[g]),
        .err   (slot_err[g]),
        .blank (slot_blank[g])
      );
    end
  endgenerate

  assign frame_done = (seen == 4'hF);

  // Publishing clears seen, but a sample on the same edge already belongs to the next frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      seen  <= 4'h0;
      value <= 16'h0;
      err   <= 4'h0;
      blank <= 4'h0;
      valid <= 1'b0;
    end else begin
      seen  <= (frame_done ? 4'h0 : seen) | load;
      valid <= frame_done;
      if (frame_done) begin
        value <= slot_nib;
        err   <= slot_err;
        blank <= slot_blank;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || frame_done)
      stale_cnt <= '0;
    else if (stale_cnt != TO_W)
      stale_cnt <= stale_cnt + 1'b1;
  end

  assign stale = (stale_cnt == TO_W);
endmodule
